// File: rtl/spart_pkg.sv
// Shared constants and state encoding for the spart register scheduler.
// Register select codes match the spart's bus, baud and status registers.
package spart_pkg;

    localparam logic [1:0] IOADDR_BUF  = 2'b00;
    localparam logic [1:0] IOADDR_STAT = 2'b01;
    localparam logic [1:0] IOADDR_DBL  = 2'b10;
    localparam logic [1:0] IOADDR_DBH  = 2'b11;

    // Raw encodings are kept as constants so older code can compare against them.
    localparam logic [2:0] ST_CFG_LO = 3'd0;
    localparam logic [2:0] ST_CFG_HI = 3'd1;
    localparam logic [2:0] ST_IDLE   = 3'd2;
    localparam logic [2:0] ST_RX_RD  = 3'd3;
    localparam logic [2:0] ST_TX_WR  = 3'd4;
    localparam logic [2:0] ST_GUARD  = 3'd5;

    typedef enum logic [2:0] {
        CFG_LO = ST_CFG_LO,
        CFG_HI = ST_CFG_HI,
        IDLE   = ST_IDLE,
        RX_RD  = ST_RX_RD,
        TX_WR  = ST_TX_WR,
        GUARD  = ST_GUARD
    } sched_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spart_sched_rr_arbiter.sv
// Combinational round-robin arbiter with a packet lock.
// While locked, only the locked requester may win so packets stay contiguous.
module rr_arbiter
    import spart_pkg::*;
#(
    parameter int NREQ = 2,
    localparam int IW = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    input  logic            lock_en,
    input  logic [IW-1:0]   lock_idx,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx
);

    int   cand;
    logic found;

    // Search starts at ptr and wraps, so the first valid requester after the last winner is picked.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = 0;
        found     = 1'b0;
        if (lock_en) begin
            if (req[lock_idx]) begin
                grant[lock_idx] = 1'b1;
                grant_idx       = lock_idx;
            end
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                cand = int'(ptr) + k;
                if (cand >= NREQ) begin
                    cand = cand - NREQ;
                end
                if (!found && req[cand]) begin
                    found       = 1'b1;
                    grant[cand] = 1'b1;
                    grant_idx   = IW'(cand);
                end
            end
        end
    end

endmodule

// File: rtl/spart_sched.sv
// Scheduler owning the spart register interface: divisor setup, RX draining, TX round-robin.
// Optional per-requester and RX byte counters are enabled by defining SPART_SCHED_STATS_EN.
module spart_sched
    import spart_pkg::*;
#(
    parameter int          NREQ      = 2,
    parameter logic [15:0] DIVISOR   = 16'h0145,
    parameter int          GUARD_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              iocs,
    output logic              iorw,
    output logic [1:0]        ioaddr,
    output logic [7:0]        databus_o,
    output logic              databus_oe,
    input  logic [7:0]        databus_i,
    input  logic              rda,
    input  logic              tbr,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_last,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic [7:0]        rx_data,
    output logic              rx_valid,
    output logic              cfg_done
`ifdef SPART_SCHED_STATS_EN
    ,
    output logic [16*NREQ-1:0] tx_count,
    output logic [15:0]        rx_count
`endif
);

    localparam int IW = idx_w(NREQ);
    localparam int GW = 4;

    sched_state_t    state;
    sched_state_t    state_nx;
    logic [IW-1:0]   rr_ptr;
    logic            lock_en;
    logic [IW-1:0]   lock_idx;
    logic [IW-1:0]   tx_idx;
    logic [7:0]      tx_byte;
    logic            tx_last;
    logic [GW-1:0]   guard_cnt;
    logic [NREQ-1:0] grant;
    logic [IW-1:0]   grant_idx;
    logic            take_rx;
    logic            take_tx;

    logic            bus_cs;
    logic            bus_rw;
    logic [1:0]      bus_addr;
    logic [7:0]      bus_data;
    logic            bus_oe;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .lock_en   (lock_en),
        .lock_idx  (lock_idx),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // RX service always beats TX when both are ready in the same idle cycle.
    assign take_rx   = (state == IDLE) && rda;
    assign take_tx   = (state == IDLE) && !rda && tbr && (|grant);
    assign req_ready = take_tx ? grant : '0;

    always_comb begin
        state_nx = state;
        case (state)
            CFG_LO: state_nx = CFG_HI;
            CFG_HI: state_nx = IDLE;
            IDLE: begin
                if (take_rx) begin
                    state_nx = RX_RD;
                end else if (take_tx) begin
                    state_nx = TX_WR;
                end
            end
            RX_RD:  state_nx = IDLE;
            TX_WR:  state_nx = GUARD;
            GUARD: begin
                if (guard_cnt == GW'(GUARD_CYC - 1)) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = CFG_LO;
        endcase
    end

    always_comb begin
        bus_cs   = 1'b0;
        bus_rw   = 1'b0;
        bus_addr = IOADDR_BUF;
        bus_data = 8'h00;
        bus_oe   = 1'b0;
        case (state)
            CFG_LO: begin
                bus_cs   = 1'b1;
                bus_addr = IOADDR_DBL;
                bus_data = DIVISOR[7:0];
                bus_oe   = 1'b1;
            end
            CFG_HI: begin
                bus_cs   = 1'b1;
                bus_addr = IOADDR_DBH;
                bus_data = DIVISOR[15:8];
                bus_oe   = 1'b1;
            end
            RX_RD: begin
                bus_cs   = 1'b1;
                bus_rw   = 1'b1;
                bus_addr = IOADDR_BUF;
            end
            TX_WR: begin
                bus_cs   = 1'b1;
                bus_addr = IOADDR_BUF;
                bus_data = tx_byte;
                bus_oe   = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset parks the state in CFG_LO, so the bus is masked to drop any access immediately.
    assign iocs       = bus_cs & ~rst;
    assign iorw       = bus_rw & ~rst;
    assign ioaddr     = rst ? 2'b00 : bus_addr;
    assign databus_o  = rst ? 8'h00 : bus_data;
    assign databus_oe = bus_oe & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= CFG_LO;
            rr_ptr    <= '0;
            lock_en   <= 1'b0;
            lock_idx  <= '0;
            tx_idx    <= '0;
            tx_byte   <= 8'h00;
            tx_last   <= 1'b0;
            guard_cnt <= '0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            cfg_done  <= 1'b0;
        end else begin
            state    <= state_nx;
            rx_valid <= (state == RX_RD);
            if (state == RX_RD) begin
                rx_data <= databus_i;
            end
            if (state == CFG_HI) begin
                cfg_done <= 1'b1;
            end
            if (take_tx) begin
                tx_idx  <= grant_idx;
                tx_byte <= req_data[int'(grant_idx)*8 +: 8];
                tx_last <= req_last[grant_idx];
            end
            // Packet boundary bookkeeping: a last byte releases the lock and advances fairness.
            if (state == TX_WR) begin
                guard_cnt <= '0;
                if (tx_last) begin
                    lock_en <= 1'b0;
                    if (int'(tx_idx) == NREQ - 1) begin
                        rr_ptr <= '0;
                    end else begin
                        rr_ptr <= tx_idx + IW'(1);
                    end
                end else begin
                    lock_en  <= 1'b1;
                    lock_idx <= tx_idx;
                end
            end
            if (state == GUARD) begin
                guard_cnt <= guard_cnt + GW'(1);
            end
        end
    end

`ifdef SPART_SCHED_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_count <= '0;
            rx_count <= 16'h0000;
        end else begin
            if (state == RX_RD) begin
                rx_count <= rx_count + 16'd1;
            end
            if (state == TX_WR) begin
                tx_count[int'(tx_idx)*16 +: 16] <= tx_count[int'(tx_idx)*16 +: 16] + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_spart_sched.sv
// Bench for spart_sched: a transaction-level schedule model checked every cycle,
// plus literal expectations for divisor writes, grant order and received data.
`timescale 1ns/1ps
module tb_spart_sched;

    localparam int          NREQ      = 2;
    localparam int          GUARD_CYC = 2;
    localparam logic [15:0] DIVISOR   = 16'h0145;

    typedef struct {
        logic       cs;
        logic       rw;
        logic [1:0] addr;
        logic [7:0] data;
        logic       oe;
    } access_t;

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         gap;
    } txbyte_t;

    typedef struct {
        logic [1:0] addr;
        logic [7:0] data;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              iocs;
    logic              iorw;
    logic [1:0]        ioaddr;
    logic [7:0]        databus_o;
    logic              databus_oe;
    logic [7:0]        databus_i = 8'h00;
    logic              rda = 1'b0;
    logic              tbr = 1'b0;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_last;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              cfg_done;
`ifdef SPART_SCHED_STATS_EN
    logic [16*NREQ-1:0] tx_count;
    logic [15:0]        rx_count;
`endif

    always #5 clk = ~clk;

    spart_sched #(.NREQ(NREQ), .DIVISOR(DIVISOR), .GUARD_CYC(GUARD_CYC)) dut (
        .clk        (clk),
        .rst        (rst),
        .iocs       (iocs),
        .iorw       (iorw),
        .ioaddr     (ioaddr),
        .databus_o  (databus_o),
        .databus_oe (databus_oe),
        .databus_i  (databus_i),
        .rda        (rda),
        .tbr        (tbr),
        .req_valid  (req_valid),
        .req_last   (req_last),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .cfg_done   (cfg_done)
`ifdef SPART_SCHED_STATS_EN
        ,
        .tx_count   (tx_count),
        .rx_count   (rx_count)
`endif
    );

    int compared   = 0;
    int mismatched = 0;

    access_t         sched_q[$];
    txbyte_t         txq[NREQ][$];
    int              m_ptr = 0;
    bit              m_lock = 1'b0;
    int              m_lock_idx = 0;
    int              post_rst = 0;
    bit              rx_pend = 1'b0;
    logic [7:0]      rx_pend_data = 8'h00;
    logic [7:0]      m_rx_data = 8'h00;
    logic [NREQ-1:0] last_ready = '0;
    int              rd_count = 0;
    int              grant_log[$];
    wr_t             wr_log[$];
    logic [7:0]      rx_log[$];

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic access_t mkAcc(input logic cs, input logic rw, input logic [1:0] addr,
                                      input logic [7:0] data, input logic oe);
        access_t a;
        a.cs = cs; a.rw = rw; a.addr = addr; a.data = data; a.oe = oe;
        return a;
    endfunction

    // Requester chosen by the fairness rules: locked owner only, else first valid from the pointer.
    function automatic int pickRequester(input logic [NREQ-1:0] v);
        if (m_lock) return v[m_lock_idx] ? m_lock_idx : -1;
        for (int k = 0; k < NREQ; k++) begin
            if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic modelStep();
        access_t         e;
        logic [NREQ-1:0] exp_ready;
        logic            exp_rxv;
        int              g;
        if (rst) begin
            sched_q.delete();
            sched_q.push_back(mkAcc(1'b1, 1'b0, 2'b10, DIVISOR[7:0], 1'b1));
            sched_q.push_back(mkAcc(1'b1, 1'b0, 2'b11, DIVISOR[15:8], 1'b1));
            m_ptr = 0; m_lock = 1'b0; m_lock_idx = 0; post_rst = 0;
            rx_pend = 1'b0; m_rx_data = 8'h00; last_ready = '0;
            checkOutput("rst_iocs", iocs, 0);
            checkOutput("rst_oe", databus_oe, 0);
            checkOutput("rst_req_ready", req_ready, 0);
            checkOutput("rst_rx_valid", rx_valid, 0);
            checkOutput("rst_rx_data", rx_data, 0);
            checkOutput("rst_cfg_done", cfg_done, 0);
            return;
        end
        exp_ready = '0;
        exp_rxv   = rx_pend;
        if (rx_pend) m_rx_data = rx_pend_data;
        rx_pend = 1'b0;
        e = mkAcc(1'b0, 1'b0, 2'b00, 8'h00, 1'b0);
        if (sched_q.size() > 0) begin
            e = sched_q.pop_front();
        end else if (rda) begin
            sched_q.push_back(mkAcc(1'b1, 1'b1, 2'b00, 8'h00, 1'b0));
        end else if (tbr) begin
            g = pickRequester(req_valid);
            if (g >= 0) begin
                exp_ready[g] = 1'b1;
                sched_q.push_back(mkAcc(1'b1, 1'b0, 2'b00, req_data[8*g +: 8], 1'b1));
                for (int q = 0; q < GUARD_CYC; q++) sched_q.push_back(mkAcc(1'b0, 1'b0, 2'b00, 8'h00, 1'b0));
                if (req_last[g]) begin
                    m_lock = 1'b0;
                    m_ptr  = (g + 1) % NREQ;
                end else begin
                    m_lock     = 1'b1;
                    m_lock_idx = g;
                end
            end
        end
        if (e.cs && e.rw) begin
            rx_pend      = 1'b1;
            rx_pend_data = databus_i;
        end
        checkOutput("iocs", iocs, e.cs);
        checkOutput("databus_oe", databus_oe, e.oe);
        if (e.cs) begin
            checkOutput("iorw", iorw, e.rw);
            checkOutput("ioaddr", ioaddr, e.addr);
        end
        if (e.oe) checkOutput("databus_o", databus_o, e.data);
        checkOutput("req_ready", req_ready, exp_ready);
        checkOutput("rx_valid", rx_valid, exp_rxv);
        checkOutput("rx_data", rx_data, m_rx_data);
        checkOutput("cfg_done", cfg_done, post_rst >= 2);
        if (iocs && !iorw) wr_log.push_back('{addr: ioaddr, data: databus_o});
        if (iocs && iorw) rd_count++;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) grant_log.push_back(i);
        if (rx_valid) rx_log.push_back(rx_data);
        last_ready = req_ready;
        post_rst++;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            modelStep();
        end
    end

    // Requester driver: presents queue heads, honours gaps, pops on an observed accept.
    initial begin
        txbyte_t cur;
        req_valid = '0; req_last = '0; req_data = '0;
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < NREQ; i++) begin
                if (last_ready[i] && txq[i].size() > 0) void'(txq[i].pop_front());
                req_valid[i] = 1'b0; req_last[i] = 1'b0; req_data[8*i +: 8] = 8'h00;
                if (txq[i].size() > 0) begin
                    cur = txq[i][0];
                    if (cur.gap > 0) begin
                        cur.gap--;
                        txq[i][0] = cur;
                    end else begin
                        req_valid[i] = 1'b1; req_last[i] = cur.last; req_data[8*i +: 8] = cur.data;
                    end
                end
            end
        end
    end

    task automatic pushByte(input int i, input logic [7:0] d, input logic l, input int gap);
        txbyte_t t;
        t.data = d; t.last = l; t.gap = gap;
        txq[i].push_back(t);
    endtask

    task automatic applyStimulus(input logic rda_v, input logic tbr_v, input logic [7:0] dbi, input int cycles);
        rda = rda_v; tbr = tbr_v; databus_i = dbi;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic clearLogs();
        grant_log.delete(); wr_log.delete(); rx_log.delete();
    endtask

    task automatic waitDrain(input int bound);
        int n = 0;
        while ((txq[0].size() != 0 || txq[1].size() != 0 || sched_q.size() != 0) && n < bound) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= bound) begin
            compared++; mismatched++;
            $display("[TB] FAIL drain_timeout: got busy after %0d cycles, expected drained", n);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic waitRead(input int bound);
        int start = rd_count;
        int n = 0;
        rda = 1'b1;
        while (rd_count == start && n < bound) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= bound) begin
            compared++; mismatched++;
            $display("[TB] FAIL read_timeout: got no read after %0d cycles, expected one", n);
        end
        rda = 1'b0;
    endtask

    function automatic int glog(input int k);
        return (grant_log.size() > k) ? grant_log[k] : -1;
    endfunction

    initial begin
        int n;
        // Reset and divisor programming.
        applyStimulus(1'b0, 1'b0, 8'h00, 3);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00, 6);
        checkOutput("cfg_wr_count", wr_log.size(), 2);
        checkOutput("cfg_lo_addr", wr_log[0].addr, 2'b10);
        checkOutput("cfg_lo_data", wr_log[0].data, 8'h45);
        checkOutput("cfg_hi_addr", wr_log[1].addr, 2'b11);
        checkOutput("cfg_hi_data", wr_log[1].data, 8'h01);
        checkOutput("cfg_done_lit", cfg_done, 1);

        // Single byte from requester 0.
        clearLogs();
        applyStimulus(1'b0, 1'b1, 8'h00, 0);
        pushByte(0, 8'hA5, 1'b1, 0);
        waitDrain(50);
        checkOutput("single_grant", glog(0), 0);
        checkOutput("single_wr_data", wr_log[0].data, 8'hA5);
        checkOutput("single_wr_addr", wr_log[0].addr, 2'b00);

        // RX and TX ready in the same idle cycle: read first.
        applyStimulus(1'b0, 1'b0, 8'h00, 1);
        pushByte(1, 8'h5A, 1'b1, 0);
        applyStimulus(1'b0, 1'b0, 8'h00, 3);
        clearLogs();
        tbr = 1'b1; databus_i = 8'h3C;
        waitRead(20);
        waitDrain(50);
        checkOutput("rx_first_data", (rx_log.size() > 0) ? rx_log[0] : 8'hxx, 8'h3C);
        checkOutput("rx_then_tx_grant", glog(0), 1);
        checkOutput("rx_then_tx_data", wr_log[0].data, 8'h5A);

        // Both requesters streaming single-byte packets alternate.
        clearLogs();
        for (int b = 0; b < 4; b++) begin
            pushByte(0, 8'h10 + 8'(b), 1'b1, 0);
            pushByte(1, 8'h20 + 8'(b), 1'b1, 0);
        end
        waitDrain(200);
        checkOutput("alt_g0", glog(0), 0);
        checkOutput("alt_g1", glog(1), 1);
        checkOutput("alt_g2", glog(2), 0);
        checkOutput("alt_g3", glog(3), 1);

        // Three-byte packet from requester 0 with a stall; RX still serviced meanwhile.
        clearLogs();
        pushByte(0, 8'h30, 1'b0, 0);
        pushByte(0, 8'h31, 1'b0, 6);
        pushByte(0, 8'h32, 1'b1, 0);
        for (int b = 0; b < 3; b++) pushByte(1, 8'h40 + 8'(b), 1'b1, 0);
        applyStimulus(1'b0, 1'b1, 8'h77, 2);
        waitRead(40);
        waitDrain(200);
        checkOutput("pkt_g0", glog(0), 0);
        checkOutput("pkt_g1", glog(1), 0);
        checkOutput("pkt_g2", glog(2), 0);
        checkOutput("pkt_g3", glog(3), 1);
        checkOutput("pkt_rx", (rx_log.size() > 0) ? rx_log[0] : 8'hxx, 8'h77);

        // Move the pointer to 1, lock requester 1, then reset during its next write.
        pushByte(0, 8'hC1, 1'b1, 0);
        waitDrain(50);
        pushByte(1, 8'hC2, 1'b0, 0);
        waitDrain(50);
        pushByte(1, 8'hC3, 1'b0, 0);
        n = 0;
        while (!last_ready[1] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            compared++; mismatched++;
            $display("[TB] FAIL lock_grant_timeout: got no grant, expected requester 1");
        end
        #1;
        checkOutput("pre_rst_iocs", iocs, 1);
        rst = 1'b1;
        #1;
        checkOutput("async_rst_iocs", iocs, 0);
        checkOutput("async_rst_oe", databus_oe, 0);
        txq[0].delete(); txq[1].delete();
        clearLogs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1'b0, 1'b1, 8'h00, 4);
        checkOutput("rerun_lo_data", wr_log[0].data, 8'h45);
        checkOutput("rerun_hi_data", wr_log[1].data, 8'h01);
        clearLogs();
        pushByte(0, 8'hD0, 1'b1, 0);
        pushByte(1, 8'hD1, 1'b1, 0);
        waitDrain(100);
        checkOutput("post_rst_g0", glog(0), 0);
        checkOutput("post_rst_g1", glog(1), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 1 ms");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
